// File: rtl/ofdm_symbol_scheduler.sv
// rtl/ofdm_symbol_scheduler.sv - OFDM frame-timing scheduler feeding the FFT demodulator
//
// Tracks symbol/subframe/SFN boundaries and the CP length of every symbol once an
// SSB start has been reported, and forwards each sample with one cycle of latency.
// Optional statistics counters are built when SYMBOL_SCHED_STATS_EN is defined.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   s_axis_in_tdata/tvalid  raw time-domain samples {im, re}, not stallable
//   SSB_start_i             first CP sample of the SSB symbol
//   sfn_i/subframe_i/symbol_i  SSB timing indices, sampled with SSB_start_i
//   m_axis_out_tdata/tuser/tlast/tvalid  forwarded sample, {sfn, subframe, symbol, cp_len}
//   locked_o                timing established
//   resync_o                one-cycle pulse on realignment of a locked timing
//   cfg_err_o               one-cycle pulse on an SSB start with out-of-range indices
//   resync_cnt_o, sym_cnt_o statistics (SYMBOL_SCHED_STATS_EN only)
module ofdm_symbol_scheduler #(
    parameter int IN_DW               = 32,
    parameter int NFFT                = 8,
    parameter int CP1                 = 20 * (2 ** NFFT) / 256,
    parameter int CP2                 = 18 * (2 ** NFFT) / 256,
    parameter int SYM_PER_SF          = 14,
    parameter int SUBFRAMES_PER_FRAME = 20,
    parameter int SFN_MAX             = 1023,
    localparam int SFN_W = $clog2(SFN_MAX),
    localparam int SF_W  = $clog2(SUBFRAMES_PER_FRAME - 1),
    localparam int SYM_W = $clog2(SYM_PER_SF - 1),
    localparam int CP_W  = $clog2(CP1),
    localparam int TU_W  = SFN_W + SF_W + SYM_W + CP_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [IN_DW-1:0]  s_axis_in_tdata,
    input  logic              s_axis_in_tvalid,
    input  logic              SSB_start_i,
    input  logic [SFN_W-1:0]  sfn_i,
    input  logic [SF_W-1:0]   subframe_i,
    input  logic [SYM_W-1:0]  symbol_i,
    output logic [IN_DW-1:0]  m_axis_out_tdata,
    output logic [TU_W-1:0]   m_axis_out_tuser,
    output logic              m_axis_out_tlast,
    output logic              m_axis_out_tvalid,
    output logic              locked_o,
    output logic              resync_o,
`ifdef SYMBOL_SCHED_STATS_EN
    output logic [15:0]       resync_cnt_o,
    output logic [31:0]       sym_cnt_o,
`endif
    output logic              cfg_err_o
);

    localparam int FFT_LEN = 2 ** NFFT;
    localparam int SAMP_W  = $clog2(CP1 + FFT_LEN);

    localparam logic [SFN_W-1:0]  SFN_LAST  = SFN_W'(SFN_MAX);
    localparam logic [SF_W-1:0]   SF_LAST   = SF_W'(SUBFRAMES_PER_FRAME - 1);
    localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(SYM_PER_SF - 1);
    localparam logic [SAMP_W-1:0] LEN1_LAST = SAMP_W'(CP1 + FFT_LEN - 1);
    localparam logic [SAMP_W-1:0] LEN2_LAST = SAMP_W'(CP2 + FFT_LEN - 1);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SFN_W-1:0]    sfn_q, sfn_d;
    logic [SF_W-1:0]     sf_q, sf_d;
    logic [SYM_W-1:0]    sym_q, sym_d;
    logic [SAMP_W-1:0]   samp_q, samp_d;

    logic [IN_DW-1:0]    tdata_q;
    logic [TU_W-1:0]     tuser_q, tuser_d;
    logic                tlast_q, tvalid_q, resync_q, cfg_err_q;

    logic                ssb_ev, range_ok, aligned, load, resync_d, cfg_err_d;
    logic                emit, is_last;
    logic [SFN_W-1:0]    eff_sfn;
    logic [SF_W-1:0]     eff_sf;
    logic [SYM_W-1:0]    eff_sym;
    logic [SAMP_W-1:0]   eff_samp, sym_last;
    logic [CP_W-1:0]     cp_len;

    always_comb begin
        state_d   = state_q;
        sfn_d     = sfn_q;
        sf_d      = sf_q;
        sym_d     = sym_q;
        samp_d    = samp_q;

        ssb_ev    = s_axis_in_tvalid && SSB_start_i;
        range_ok  = (subframe_i <= SF_LAST) && (symbol_i <= SYM_LAST);
        aligned   = (samp_q == '0) && (sfn_q == sfn_i) && (sf_q == subframe_i)
                    && (sym_q == symbol_i);
        // An aligned SSB while locked is a no-op; anything else with good indices reloads.
        load      = ssb_ev && range_ok && ((state_q == ST_UNLOCKED) || !aligned);
        resync_d  = ssb_ev && range_ok && (state_q == ST_LOCKED) && !aligned;
        cfg_err_d = ssb_ev && !range_ok;
        emit      = s_axis_in_tvalid && ((state_q == ST_LOCKED) || load);

        // Counters as seen by the current sample: a reload makes it sample 0.
        eff_sfn   = load ? sfn_i      : sfn_q;
        eff_sf    = load ? subframe_i : sf_q;
        eff_sym   = load ? symbol_i   : sym_q;
        eff_samp  = load ? '0         : samp_q;

        cp_len    = (eff_sym == '0) ? CP_W'(CP1) : CP_W'(CP2);
        sym_last  = (eff_sym == '0) ? LEN1_LAST : LEN2_LAST;
        // A reloaded sample sits at index 0, so a coincident resync never raises tlast.
        is_last   = emit && (eff_samp == sym_last);
        tuser_d   = {eff_sfn, eff_sf, eff_sym, cp_len};

        if (load) begin
            state_d = ST_LOCKED;
        end

        if (emit) begin
            sfn_d = eff_sfn;
            sf_d  = eff_sf;
            sym_d = eff_sym;
            if (is_last) begin
                samp_d = '0;
                if (eff_sym == SYM_LAST) begin
                    sym_d = '0;
                    if (eff_sf == SF_LAST) begin
                        sf_d  = '0;
                        sfn_d = (eff_sfn == SFN_LAST) ? '0 : eff_sfn + 1'b1;
                    end else begin
                        sf_d = eff_sf + 1'b1;
                    end
                end else begin
                    sym_d = eff_sym + 1'b1;
                end
            end else begin
                samp_d = eff_samp + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_UNLOCKED;
            sfn_q     <= '0;
            sf_q      <= '0;
            sym_q     <= '0;
            samp_q    <= '0;
            tdata_q   <= '0;
            tuser_q   <= '0;
            tlast_q   <= 1'b0;
            tvalid_q  <= 1'b0;
            resync_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sfn_q     <= sfn_d;
            sf_q      <= sf_d;
            sym_q     <= sym_d;
            samp_q    <= samp_d;
            if (s_axis_in_tvalid) begin
                tdata_q <= s_axis_in_tdata;
            end
            if (emit) begin
                tuser_q <= tuser_d;
            end
            tlast_q   <= is_last;
            tvalid_q  <= emit;
            resync_q  <= resync_d;
            cfg_err_q <= cfg_err_d;
        end
    end

`ifdef SYMBOL_SCHED_STATS_EN
    logic [15:0] resync_cnt_q;
    logic [31:0] sym_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            resync_cnt_q <= '0;
            sym_cnt_q    <= '0;
        end else begin
            if (resync_d && (resync_cnt_q != 16'hFFFF)) begin
                resync_cnt_q <= resync_cnt_q + 16'd1;
            end
            if (is_last) begin
                sym_cnt_q <= sym_cnt_q + 32'd1;
            end
        end
    end

    assign resync_cnt_o = resync_cnt_q;
    assign sym_cnt_o    = sym_cnt_q;
`endif

    assign m_axis_out_tdata  = tdata_q;
    assign m_axis_out_tuser  = tuser_q;
    assign m_axis_out_tlast  = tlast_q;
    assign m_axis_out_tvalid = tvalid_q;
    assign locked_o          = (state_q == ST_LOCKED);
    assign resync_o          = resync_q;
    assign cfg_err_o         = cfg_err_q;

endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// tb/tb_ofdm_symbol_scheduler.sv - directed self-checking bench for ofdm_symbol_scheduler
module tb_ofdm_symbol_scheduler;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        ssb;
    logic [9:0]  sfn_in;
    logic [4:0]  sf_in;
    logic [3:0]  sym_in;
    logic [31:0] m_tdata;
    logic [23:0] m_tuser;
    logic        m_tlast, m_tvalid, locked_o, resync_o, cfg_err_o;
`ifdef SYMBOL_SCHED_STATS_EN
    logic [15:0] resync_cnt_o;
    logic [31:0] sym_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    ofdm_symbol_scheduler dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .s_axis_in_tdata   (s_tdata),
        .s_axis_in_tvalid  (s_tvalid),
        .SSB_start_i       (ssb),
        .sfn_i             (sfn_in),
        .subframe_i        (sf_in),
        .symbol_i          (sym_in),
        .m_axis_out_tdata  (m_tdata),
        .m_axis_out_tuser  (m_tuser),
        .m_axis_out_tlast  (m_tlast),
        .m_axis_out_tvalid (m_tvalid),
        .locked_o          (locked_o),
        .resync_o          (resync_o),
`ifdef SYMBOL_SCHED_STATS_EN
        .resync_cnt_o      (resync_cnt_o),
        .sym_cnt_o         (sym_cnt_o),
`endif
        .cfg_err_o         (cfg_err_o)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] tu(input int sfn, input int sf, input int sym, input int cp);
        return {10'(sfn), 5'(sf), 4'(sym), 5'(cp)};
    endfunction

    // Drive one cycle of input, then sample outputs 1 time unit after the edge.
    task automatic send(input logic v, input logic s, input int sfn, input int sf, input int sym,
                        input logic [31:0] d);
        s_tvalid = v;
        ssb      = s;
        sfn_in   = 10'(sfn);
        sf_in    = 5'(sf);
        sym_in   = 4'(sym);
        s_tdata  = d;
        @(posedge clk_i);
        #1;
    endtask

    task automatic plain(input logic [31:0] d);
        send(1'b1, 1'b0, 0, 0, 0, d);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        send(1'b0, 1'b0, 0, 0, 0, 32'h0);
        send(1'b0, 1'b0, 0, 0, 0, 32'h0);
        reset_i = 1'b0;
    endtask

    initial begin
        int seen;
        int t1, t2;
        int nvalid, cyc, follow_err, tlast_at, extra_tlast;
        logic v;

        reset_i = 1'b1;
        s_tvalid = 1'b0; ssb = 1'b0; sfn_in = '0; sf_in = '0; sym_in = '0; s_tdata = '0;
        do_reset();
        check_val("reset_tvalid", m_tvalid, 0);
        check_val("reset_locked", locked_o, 0);
        check_val("reset_tuser", m_tuser, 0);

        // 1: unlocked samples are dropped
        seen = 0;
        for (int k = 0; k < 1000; k++) begin
            plain(32'(k));
            if (m_tvalid || locked_o) seen++;
        end
        check_val("unlocked_drop", seen, 0);

        // 2: lock at sfn 5, subframe 3, symbol 0; CP sequence
        t1 = -1; t2 = -1;
        send(1'b1, 1'b1, 5, 3, 0, 32'hCAFE_0001);
        check_val("lock_tvalid", m_tvalid, 1);
        check_val("lock_locked", locked_o, 1);
        check_val("lock_tdata", m_tdata, 32'hCAFE_0001);
        check_val("lock_tuser_sym0", m_tuser, tu(5, 3, 0, 20));
        for (int k = 1; k < 600; k++) begin
            plain(32'(k));
            if (k == 276) check_val("tuser_sym1", m_tuser, tu(5, 3, 1, 18));
            if (m_tlast) begin
                if (t1 < 0) t1 = k;
                else if (t2 < 0) t2 = k;
            end
        end
        check_val("first_tlast_idx", t1, 275);
        check_val("second_tlast_gap", t2 - t1, 274);

        // 3: full wrap from sfn 1023 / subframe 19 / symbol 13
        do_reset();
        send(1'b1, 1'b1, 1023, 19, 13, 32'h0);
        check_val("wrap_tuser_start", m_tuser, tu(1023, 19, 13, 18));
        t1 = -1;
        for (int k = 1; k < 550; k++) begin
            plain(32'(k));
            if (k == 273) check_val("wrap_tlast_273", m_tlast, 1);
            if (k == 274) check_val("wrap_tuser_zero", m_tuser, tu(0, 0, 0, 20));
            if (k > 273 && m_tlast && t1 < 0) t1 = k;
        end
        check_val("wrap_tlast_sym0", t1, 549);

        // 4: random tvalid gaps through symbol 2
        do_reset();
        send(1'b1, 1'b1, 0, 0, 2, 32'h0);
        check_val("gap_lock_tvalid", m_tvalid, 1);
        nvalid = 1; cyc = 0; follow_err = 0; tlast_at = -1; extra_tlast = 0;
        while (nvalid < 274 && cyc < 5000) begin
            v = 1'($urandom_range(0, 1));
            send(v, 1'b0, 0, 0, 0, 32'(cyc));
            if (m_tvalid !== v) follow_err++;
            if (m_tlast) begin
                if (v && tlast_at < 0) tlast_at = nvalid;
                else extra_tlast++;
            end
            if (v) nvalid++;
            cyc++;
        end
        check_val("gap_budget", nvalid, 274);
        check_val("gap_follow", follow_err, 0);
        check_val("gap_tlast_idx", tlast_at, 273);
        check_val("gap_extra_tlast", extra_tlast, 0);

        // 5: resync behaviour, now at symbol 3 sample 0
        send(1'b1, 1'b1, 0, 0, 3, 32'h0);
        check_val("aligned_resync", resync_o, 0);
        check_val("aligned_tuser", m_tuser, tu(0, 0, 3, 18));
        for (int k = 1; k < 100; k++) plain(32'(k));
        send(1'b1, 1'b1, 0, 0, 4, 32'h0);
        check_val("mis_resync", resync_o, 1);
        check_val("mis_tuser", m_tuser, tu(0, 0, 4, 18));
        check_val("mis_tlast", m_tlast, 0);
        plain(32'h1);
        check_val("mis_resync_pulse", resync_o, 0);
        check_val("mis_tuser_next", m_tuser, tu(0, 0, 4, 18));
        for (int k = 2; k < 273; k++) plain(32'(k));
        send(1'b1, 1'b1, 0, 0, 7, 32'h0);
        check_val("coinc_tlast", m_tlast, 0);
        check_val("coinc_resync", resync_o, 1);
        check_val("coinc_tuser", m_tuser, tu(0, 0, 7, 18));

        // 6: out-of-range indices and reset mid-symbol
        send(1'b1, 1'b1, 0, 0, 14, 32'h0);
        check_val("err_pulse", cfg_err_o, 1);
        check_val("err_no_resync", resync_o, 0);
        check_val("err_tuser_kept", m_tuser, tu(0, 0, 7, 18));
        check_val("err_locked", locked_o, 1);
        plain(32'h2);
        check_val("err_pulse_end", cfg_err_o, 0);
        reset_i = 1'b1;
        send(1'b1, 1'b0, 0, 0, 0, 32'h1234_5678);
        check_val("rst_tvalid", m_tvalid, 0);
        check_val("rst_locked", locked_o, 0);
        check_val("rst_tuser", m_tuser, 0);
        check_val("rst_tdata", m_tdata, 0);
        reset_i = 1'b0;
        send(1'b1, 1'b1, 0, 20, 0, 32'h0);
        check_val("err_unlocked_pulse", cfg_err_o, 1);
        check_val("err_unlocked_state", locked_o, 0);
        check_val("err_unlocked_tvalid", m_tvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
